// File: rtl/single_port_blockram_arbiter_pkg.sv
// Shared constants and helpers for the single-port blockram arbiter.
// Holds the default geometry of the shared RAM and a helper that sizes the
// flattened per-client buses carried by the arbiter interface.
package single_port_blockram_arbiter_pkg;

  localparam int DEFAULT_NUM_REQUESTERS = 4;
  localparam int DEFAULT_ELEMENT_W      = 64;
  localparam int DEFAULT_NUMBER_SETS    = 64;

  // Field widths of the registered command that is not parameter dependent.
  localparam int CMD_WRITE_W = 1;

  // Width of a bus that packs one slice of slice_w bits per client.
  function automatic int flat_width(input int num_clients, input int slice_w);
    return num_clients * slice_w;
  endfunction

endpackage

// File: rtl/single_port_blockram_arbiter_if.sv
// Client/RAM bundle of the single-port blockram arbiter.
// Client side : request_valid_in, request_ready_out, request_write_in,
//               request_addr_in (flattened), request_data_in (flattened),
//               response_valid_out, response_data_out.
// RAM side    : bram_access_en_out, bram_write_en_out, bram_addr_out,
//               bram_write_element_out, bram_read_element_in.
// Modport slave is the arbiter's view, master is the view of the
// clients and RAM that surround it.
interface single_port_blockram_arbiter_if
  import single_port_blockram_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS              = DEFAULT_NUM_REQUESTERS,
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = DEFAULT_ELEMENT_W,
  parameter int NUMBER_SETS                 = DEFAULT_NUMBER_SETS,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
);

  logic [NUM_REQUESTERS-1:0]                    request_valid_in;
  logic [NUM_REQUESTERS-1:0]                    request_ready_out;
  logic [NUM_REQUESTERS-1:0]                    request_write_in;
  logic [flat_width(NUM_REQUESTERS, SET_PTR_WIDTH_IN_BITS)-1:0]       request_addr_in;
  logic [flat_width(NUM_REQUESTERS, SINGLE_ELEMENT_SIZE_IN_BITS)-1:0] request_data_in;
  logic [NUM_REQUESTERS-1:0]                    response_valid_out;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]       response_data_out;

  logic                                         bram_access_en_out;
  logic                                         bram_write_en_out;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]             bram_addr_out;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]       bram_write_element_out;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]       bram_read_element_in;

  modport slave (
    input  request_valid_in, request_write_in, request_addr_in, request_data_in,
    input  bram_read_element_in,
    output request_ready_out, response_valid_out, response_data_out,
    output bram_access_en_out, bram_write_en_out, bram_addr_out, bram_write_element_out
  );

  modport master (
    output request_valid_in, request_write_in, request_addr_in, request_data_in,
    output bram_read_element_in,
    input  request_ready_out, response_valid_out, response_data_out,
    input  bram_access_en_out, bram_write_en_out, bram_addr_out, bram_write_element_out
  );

endinterface

// File: rtl/single_port_blockram_arbiter_rr.sv
// Combinational round-robin arbiter, reusable by any shared-resource block.
// Ports:
//   request_i   : per-client request vector
//   pointer_i   : client index with highest priority this cycle
//   grant_o     : one-hot grant (all zero when nothing requests)
//   grant_idx_o : encoded index of the granted client
//   grant_vld_o : a grant was issued
module round_robin_arbiter
  import single_port_blockram_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS        = DEFAULT_NUM_REQUESTERS,
  parameter int REQ_PTR_WIDTH_IN_BITS = $clog2(NUM_REQUESTERS)
)(
  input  logic [NUM_REQUESTERS-1:0]        request_i,
  input  logic [REQ_PTR_WIDTH_IN_BITS-1:0] pointer_i,
  output logic [NUM_REQUESTERS-1:0]        grant_o,
  output logic [REQ_PTR_WIDTH_IN_BITS-1:0] grant_idx_o,
  output logic                             grant_vld_o
);

  // Walk the clients starting at the pointer. The wrap is a subtraction rather
  // than a bit mask so non-power-of-two client counts rotate correctly.
  always_comb begin
    int idx;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      idx = int'(pointer_i) + k;
      if (idx >= NUM_REQUESTERS) idx = idx - NUM_REQUESTERS;
      if (!grant_vld_o && request_i[idx]) begin
        grant_vld_o  = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = REQ_PTR_WIDTH_IN_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/single_port_blockram_arbiter.sv
// Shares one single-port blockram among NUM_REQUESTERS clients.
// A round-robin grant selects one client per cycle; the accepted request is
// registered into a command stage that drives the RAM, and read data returns
// to the originating client two cycles after acceptance.
// Ports:
//   clk_in   : clock, all logic on the rising edge
//   reset_in : synchronous active-high reset
//   bus      : client handshake, response and RAM command bundle (slave view)
module single_port_blockram_arbiter
  import single_port_blockram_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS              = DEFAULT_NUM_REQUESTERS,
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = DEFAULT_ELEMENT_W,
  parameter int NUMBER_SETS                 = DEFAULT_NUMBER_SETS,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
  parameter int REQ_PTR_WIDTH_IN_BITS       = $clog2(NUM_REQUESTERS)
)(
  input  logic clk_in,
  input  logic reset_in,
  single_port_blockram_arbiter_if.slave bus
);

  localparam int N  = NUM_REQUESTERS;
  localparam int A  = SET_PTR_WIDTH_IN_BITS;
  localparam int W  = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int RW = REQ_PTR_WIDTH_IN_BITS;

  typedef struct packed {
    logic [CMD_WRITE_W-1:0] write;
    logic [A-1:0]           addr;
    logic [W-1:0]           data;
    logic [RW-1:0]          id;
  } cmd_t;

  logic [N-1:0]  req_vld;
  logic [N-1:0]  grant;
  logic [RW-1:0] grant_idx;
  logic          grant_vld;
  logic [RW-1:0] ptr_q;
  logic [RW-1:0] ptr_d;
  cmd_t          cmd_p0;

  logic          cmd_vld_p1_q;
  logic          wr_p1_q;
  logic [A-1:0]  addr_p1_q;
  logic [W-1:0]  wdata_p1_q;
  logic          rd_vld_p1_q;
  logic [RW-1:0] rd_id_p1_q;

  logic [N-1:0]  resp_vld_p2_d;
  logic [N-1:0]  resp_vld_p2_q;
  logic [W-1:0]  resp_data_p2_q;

  // Stage p0: arbitration. Requests are masked during reset so no handshake
  // can complete in a reset cycle.
  assign req_vld = reset_in ? '0 : bus.request_valid_in;

  round_robin_arbiter #(
    .NUM_REQUESTERS        (N),
    .REQ_PTR_WIDTH_IN_BITS (RW)
  ) u_rr (
    .request_i   (req_vld),
    .pointer_i   (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  assign bus.request_ready_out = grant;

  always_comb begin
    cmd_p0.write = bus.request_write_in[grant_idx];
    cmd_p0.addr  = bus.request_addr_in[grant_idx*A +: A];
    cmd_p0.data  = bus.request_data_in[grant_idx*W +: W];
    cmd_p0.id    = grant_idx;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + RW'(1);
  end

  // Stage p1: registered command driving the RAM. Address and data hold
  // through idle cycles; write enable drops with access enable so an idle
  // cycle never looks like a write.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ptr_q        <= '0;
      cmd_vld_p1_q <= 1'b0;
      wr_p1_q      <= 1'b0;
      addr_p1_q    <= '0;
      wdata_p1_q   <= '0;
      rd_vld_p1_q  <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      cmd_vld_p1_q <= grant_vld;
      wr_p1_q      <= grant_vld & cmd_p0.write[0];
      rd_vld_p1_q  <= grant_vld & ~cmd_p0.write[0];
      if (grant_vld) begin
        addr_p1_q  <= cmd_p0.addr;
        wdata_p1_q <= cmd_p0.data;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (grant_vld && !cmd_p0.write[0]) rd_id_p1_q <= cmd_p0.id;
  end

  assign bus.bram_access_en_out     = cmd_vld_p1_q;
  assign bus.bram_write_en_out      = wr_p1_q;
  assign bus.bram_addr_out          = addr_p1_q;
  assign bus.bram_write_element_out = wdata_p1_q;

  // Stage p2: response. The RAM returns read data combinationally from the
  // registered address, so it is captured on the same edge that completes
  // the access and presented for one cycle with the originating client id.
  always_comb begin
    resp_vld_p2_d = '0;
    if (rd_vld_p1_q) resp_vld_p2_d[rd_id_p1_q] = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      resp_vld_p2_q  <= '0;
      resp_data_p2_q <= '0;
    end else begin
      resp_vld_p2_q <= resp_vld_p2_d;
      if (rd_vld_p1_q) resp_data_p2_q <= bus.bram_read_element_in;
    end
  end

  assign bus.response_valid_out = resp_vld_p2_q;
  assign bus.response_data_out  = resp_data_p2_q;

endmodule

// File: tb/tb_single_port_blockram_arbiter.sv
// Scoreboard bench for single_port_blockram_arbiter. A behavioural model
// (priority pointer plus a shadow memory updated at acceptance time) predicts
// grants, RAM commands and read responses; a separate monitor pops expected
// responses whenever the DUT presents one. A second, 3-client instance covers
// non-power-of-two pointer wrap.
module tb_single_port_blockram_arbiter;

  localparam int N = 4;
  localparam int W = 64;
  localparam int D = 64;
  localparam int A = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst3;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  single_port_blockram_arbiter_if #(
    .NUM_REQUESTERS(N), .SINGLE_ELEMENT_SIZE_IN_BITS(W), .NUMBER_SETS(D)
  ) bus ();

  single_port_blockram_arbiter #(
    .NUM_REQUESTERS(N), .SINGLE_ELEMENT_SIZE_IN_BITS(W), .NUMBER_SETS(D)
  ) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  single_port_blockram_arbiter_if #(
    .NUM_REQUESTERS(3), .SINGLE_ELEMENT_SIZE_IN_BITS(8), .NUMBER_SETS(16)
  ) bus3 ();

  single_port_blockram_arbiter #(
    .NUM_REQUESTERS(3), .SINGLE_ELEMENT_SIZE_IN_BITS(8), .NUMBER_SETS(16)
  ) dut3 (
    .clk_in   (clk),
    .reset_in (rst3),
    .bus      (bus3)
  );

  assign bus3.bram_read_element_in = '0;

  // Environment RAM: asynchronous read, write on the clock edge.
  logic [W-1:0] ram [D] = '{default: '0};
  assign bus.bram_read_element_in = ram[bus.bram_addr_out];
  always @(posedge clk) begin
    if (bus.bram_access_en_out && bus.bram_write_en_out)
      ram[bus.bram_addr_out] <= bus.bram_write_element_out;
  end

  // Reference model state.
  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] mmem [D] = '{default: '0};
  int           mptr = 0;
  logic         exp_acc = 1'b0;
  logic         exp_wr = 1'b0;
  logic [A-1:0] exp_addr = '0;
  logic [W-1:0] exp_wdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus image for the main instance.
  logic [N-1:0] v;
  logic [N-1:0] w;
  logic [A-1:0] ad [N];
  logic [W-1:0] dt [N];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic idle_stim();
    v = '0;
    w = '0;
    for (int i = 0; i < N; i++) begin
      ad[i] = '0;
      dt[i] = '0;
    end
  endtask

  task automatic apply();
    bus.request_valid_in = v;
    bus.request_write_in = w;
    for (int i = 0; i < N; i++) begin
      bus.request_addr_in[i*A +: A] = ad[i];
      bus.request_data_in[i*W +: W] = dt[i];
    end
  endtask

  // Called at the falling edge of each cycle: compares the RAM command issued
  // for last cycle's grant and this cycle's grant, then advances the model
  // across the coming rising edge.
  task automatic model_check();
    int g;
    int idx;
    logic [63:0] er;
    check("bram_access_en", 64'(bus.bram_access_en_out), 64'(exp_acc));
    if (exp_acc) begin
      check("bram_write_en", 64'(bus.bram_write_en_out), 64'(exp_wr));
      check("bram_addr", 64'(bus.bram_addr_out), 64'(exp_addr));
      if (exp_wr) check("bram_wdata", bus.bram_write_element_out, exp_wdata);
    end
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    er = (g >= 0) ? (64'(1) << g) : 64'(0);
    check("request_ready", 64'(bus.request_ready_out), er);
    if (rst) begin
      mptr    = 0;
      exp_acc = 1'b0;
      while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
    end else if (g >= 0) begin
      exp_acc   = 1'b1;
      exp_wr    = w[g];
      exp_addr  = ad[g];
      exp_wdata = dt[g];
      mptr      = (g + 1) % N;
      if (w[g]) mmem[ad[g]] = dt[g];
      else q.push_back('{id: g, data: mmem[ad[g]], due: cyc + 2});
    end else begin
      exp_acc = 1'b0;
    end
  endtask

  task automatic cycle();
    apply();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic c3(input logic [2:0] vv, input logic [2:0] exp);
    bus3.request_valid_in = vv;
    @(negedge clk);
    check("ready_n3", 64'(bus3.request_ready_out), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  // Response monitor.
  initial begin
    logic [W-1:0] last_data;
    logic         rst_last;
    exp_t         e;
    last_data = '0;
    rst_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_last) last_data = '0;
      if (bus.response_valid_out !== '0) begin
        if (q.size() == 0) begin
          check("unexpected_response", 64'(bus.response_valid_out), 64'(0));
        end else begin
          e = q.pop_front();
          check("resp_id", 64'(bus.response_valid_out), 64'(1) << e.id);
          check("resp_cycle", 64'(cyc), 64'(e.due));
          check("resp_data", bus.response_data_out, e.data);
          last_data = e.data;
        end
      end else begin
        if (q.size() > 0 && q[0].due <= cyc) begin
          check("resp_missing", 64'(bus.response_valid_out), 64'(1) << q[0].id);
          void'(q.pop_front());
        end
        check("resp_data_hold", bus.response_data_out, last_data);
      end
      rst_last = rst;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    rst3 = 1'b1;
    bus3.request_valid_in = '0;
    bus3.request_write_in = '0;
    bus3.request_addr_in  = '0;
    bus3.request_data_in  = '0;

    // Reset with every client requesting.
    idle_stim();
    v = '1;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;

    // First grant after reset belongs to client 0.
    cycle();
    idle_stim();
    cycle();

    // Client 2 writes then reads back the same address.
    v = 4'b0100; w = 4'b0100; ad[2] = 6'd5; dt[2] = 64'hDEAD_BEEF;
    cycle();
    w = '0;
    cycle();
    idle_stim();
    for (int i = 0; i < 3; i++) cycle();

    // Move the pointer to 0, then all clients read addresses 1..4.
    v = 4'b1000;
    cycle();
    v = '1;
    for (int i = 0; i < N; i++) ad[i] = A'(i + 1);
    for (int i = 0; i < 8; i++) cycle();
    idle_stim();
    cycle();

    // Pointer to 3, then only clients 1 and 3 request.
    v = 4'b0100;
    cycle();
    v = 4'b1010;
    for (int i = 0; i < 3; i++) cycle();
    idle_stim();
    for (int i = 0; i < 3; i++) cycle();

    // Read accepted, reset in the following cycle: its response is dropped.
    v = 4'b0001; ad[0] = 6'd7;
    cycle();
    idle_stim();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    v = '1;
    cycle();
    idle_stim();
    for (int i = 0; i < 3; i++) cycle();

    // Single reads separated by idle cycles.
    for (int r = 0; r < 6; r++) begin
      int c;
      c = $urandom_range(0, N - 1);
      v[c]  = 1'b1;
      ad[c] = A'($urandom_range(0, D - 1));
      cycle();
      idle_stim();
      cycle();
      cycle();
    end

    // Random traffic with occasional reset.
    for (int r = 0; r < 400; r++) begin
      v = N'($urandom);
      w = N'($urandom);
      for (int i = 0; i < N; i++) begin
        ad[i] = A'($urandom_range(0, 7));
        dt[i] = {$urandom, $urandom};
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_stim();
    for (int i = 0; i < 6; i++) cycle();
    check("scoreboard_empty", 64'(q.size()), 64'(0));

    // Three-client instance: pointer wrap at a non-power-of-two count.
    @(negedge clk);
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    c3(3'b111, 3'b001);
    c3(3'b110, 3'b010);
    c3(3'b101, 3'b100);
    c3(3'b101, 3'b001);
    c3(3'b101, 3'b100);
    c3(3'b010, 3'b010);
    c3(3'b001, 3'b001);
    c3(3'b000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/single_port_blockram_arbiter.md
Name: single_port_blockram_arbiter

Overview:
- Shares one single_port_blockram instance among NUM_REQUESTERS clients using round-robin arbitration.
- Each client issues one read or write request per accepted handshake.
- Accepted requests are registered into a command stage that drives the RAM. Read data returns to the originating client two cycles after acceptance.
- Sits between the cache/table lookup clients and the blockram; it is the only master of the RAM port.

Parameters:
- NUM_REQUESTERS, 4, number of client ports; must be ≥2.
- SINGLE_ELEMENT_SIZE_IN_BITS, 64, RAM word width.
- NUMBER_SETS, 64, RAM depth.
- SET_PTR_WIDTH_IN_BITS, $clog2(NUMBER_SETS), address width (A).
- REQ_PTR_WIDTH_IN_BITS, $clog2(NUM_REQUESTERS), requester index width.

Ports:
- clk_in  in  1  clock; all logic on posedge.
- reset_in  in  1  synchronous, active-high reset.
- request_valid_in  in  NUM_REQUESTERS  per-client request valid.
- request_ready_out  out  NUM_REQUESTERS  one-hot grant; a handshake occurs when valid&ready.
- request_write_in  in  NUM_REQUESTERS  1=write, 0=read, per client.
- request_addr_in  in  NUM_REQUESTERS*A  flattened addresses; client i occupies [i*A +: A].
- request_data_in  in  NUM_REQUESTERS*SINGLE_ELEMENT_SIZE_IN_BITS  flattened write data.
- response_valid_out  out  NUM_REQUESTERS  one-hot, one-cycle pulse marking read data for client i.
- response_data_out  out  SINGLE_ELEMENT_SIZE_IN_BITS  shared read data bus.
- bram_access_en_out  out  1  to RAM access_en_in.
- bram_write_en_out  out  1  to RAM write_en_in.
- bram_addr_out  out  A  to RAM access_set_addr_in.
- bram_write_element_out  out  SINGLE_ELEMENT_SIZE_IN_BITS  to RAM write_element_in.
- bram_read_element_in  in  SINGLE_ELEMENT_SIZE_IN_BITS  from RAM read_element_out.

Behaviour:
- Reset values: priority pointer=0; all bram_* outputs=0; response_valid_out=0; response_data_out=0; internal pipeline valids=0. request_ready_out=0 for the whole cycle in which reset_in is high.

Arbitration (combinational, cycle T):
- Grant goes to the first valid client searching from the priority pointer upward, with wrap-around.
- request_ready_out is one-hot of that client, or 0 if no client is valid.
- ready depends on valid. Clients must not make valid depend on ready.
- At most one grant per cycle. No back-pressure from the RAM, so full throughput is one request per cycle.

Pointer update:
- On a grant to client g, the pointer becomes (g+1) mod NUM_REQUESTERS at the clock edge. This includes wrap from NUM_REQUESTERS-1 to 0 and works for non-power-of-2 NUM_REQUESTERS.
- With no grant, the pointer holds.

Command stage (edge ending T):
- bram_access_en_out<=1 and bram_write_en_out<=request_write_in[g].
- bram_addr_out and bram_write_element_out take client g's slices.
- A read captures g into pending_id.
- With no grant: bram_access_en_out<=0. Address and data hold their last values.

RAM access (edge ending T+1):
- The RAM performs the access.
- A read sets stage-2 valid and id.

Response (cycle T+2):
- response_valid_out[id]=1 for exactly one cycle.
- response_data_out = bram_read_element_in, registered in the arbiter's response stage at the end of T+1 (so it is valid during T+2 and held until overwritten by the next read response).
- Read latency from handshake to response_valid is 2 cycles.

Writes:
- Complete at the edge ending T+1 with no response.
- A write accepted in T followed by a read of the same address accepted in T+1 returns the new data (RAM ordering is preserved because commands issue in order).

Ordering and flow:
- Back-to-back reads from any clients return in acceptance order, one per cycle.
- A response is never dropped: clients must accept a response whenever it is presented.

Reset mid-operation:
- All in-flight commands and responses are discarded. No response_valid pulse appears after reset deasserts for a request accepted before it.
- A write already presented to the RAM in the reset cycle may or may not land; RAM contents are not reset.

Decomposition:
- Package single_port_blockram_arbiter_pkg: the flattened-slice width constants, and the command struct fields {write, addr, data, id} as localparams/typedefs.
- One sub-module: round_robin_arbiter (inputs request vector, pointer; outputs one-hot grant and encoded grant index). It is reusable by other shared-resource blocks.

Test Plan:
- Reset held 3 cycles with all requests valid -> request_ready_out=0, bram_access_en_out=0, response_valid_out=0 throughout. Then the first grant goes to client 0.
- Client 2 writes addr 5 data 0xDEAD_BEEF in cycle 10, then reads addr 5 in cycle 11 -> response_valid_out=4'b0100 in cycle 13 with response_data_out=0xDEAD_BEEF.
- All 4 clients hold valid reads to addrs 1,2,3,4 for 8 cycles -> grants 0,1,2,3,0,1,2,3. Responses one per cycle, 2 cycles after each grant, with correct ids and data.
- Pointer at 3 with only clients 1 and 3 valid -> client 3 granted, then client 1, then client 3 (wrap check). Repeat with NUM_REQUESTERS=3 to cover non-power-of-2 wrap.
- A read is accepted, then reset_in is pulsed in the next cycle -> no response_valid_out pulse afterwards and the pointer returns to 0.
- Idle cycles interleaved with single reads -> bram_access_en_out is 1 only in the cycle after each handshake. response_data_out holds its value between responses.
